// File: rtl/i2s_tx_core.sv
// ---------------------------------------------------------------------------
// i2s_tx_core -- I2S master transmitter with a one-entry sample-pair buffer.
//
// Generates SCK by dividing clk_i, drives WS (0 = left, 1 = right) and
// shifts each channel sample out MSB first with the standard one-SCK delay
// behind WS. Samples narrower than the slot are padded with zeros.
//
// Ports:
//   clk_i       system clock, all flops on its rising edge
//   rst_i       asynchronous active-high reset
//   en_i        transmit enable (stop takes effect at the next frame end)
//   data_l_i    left sample  (DATA_W bits, two's complement)
//   data_r_i    right sample (DATA_W bits, two's complement)
//   valid_i     sample pair valid
//   ready_o     input buffer empty, a pair can be accepted
//   sck_o       serial clock
//   ws_o        word select
//   sd_o        serial data
//   underrun_o  one-cycle pulse when a frame starts with an empty buffer
// ---------------------------------------------------------------------------
module i2s_tx_core #(
  parameter int DATA_W  = 24,
  parameter int SLOT_W  = 32,
  parameter int CLK_DIV = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_l_i,
  input  logic [DATA_W-1:0] data_r_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              sck_o,
  output logic              ws_o,
  output logic              sd_o,
  output logic              underrun_o
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(2 * SLOT_W);

  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(2 * SLOT_W - 1);
  localparam logic [CNT_W-1:0] SLOT_CNT = CNT_W'(SLOT_W);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sck_q, sck_d;
  logic              ws_q, ws_d;
  logic              sd_q, sd_d;
  logic              underrun_q, underrun_d;
  logic              buf_full_q, buf_full_d;
  logic [DATA_W-1:0] buf_l_q, buf_l_d;
  logic [DATA_W-1:0] buf_r_q, buf_r_d;
  logic [DATA_W-1:0] frm_l_q, frm_l_d;
  logic [DATA_W-1:0] frm_r_q, frm_r_d;

  // Bit k of a slot (k = 0 is the MSB); positions beyond the sample are 0.
  function automatic logic slot_bit(input logic [DATA_W-1:0] s,
                                    input logic [CNT_W-1:0]  k);
    logic r;
    r = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (k == CNT_W'(i)) begin
        r = s[DATA_W-1-i];
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Next-state logic: divider, bit counter, serial outputs and buffer.
  always_comb begin
    logic             accept;
    logic             frame_load;
    logic [CNT_W-1:0] cnt_nx;

    state_d    = state_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    sck_d      = sck_q;
    ws_d       = ws_q;
    sd_d       = sd_q;
    underrun_d = 1'b0;
    buf_full_d = buf_full_q;
    buf_l_d    = buf_l_q;
    buf_r_d    = buf_r_q;
    frm_l_d    = frm_l_q;
    frm_r_d    = frm_r_q;
    accept     = valid_i & ~buf_full_q;
    frame_load = 1'b0;
    cnt_nx     = '0;

    case (state_q)
      IDLE: begin
        sck_d = 1'b0;
        ws_d  = 1'b0;
        sd_d  = 1'b0;
        div_d = '0;
        cnt_d = '0;
        if (en_i) begin
          state_d    = RUN;
          frame_load = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (div_q == DIV_MAX) begin
          div_d = '0;
          sck_d = ~sck_q;
          if (sck_q) begin
            // Falling SCK event: the bit leaving now is slot position cnt_q,
            // one SCK behind the WS value derived from the new count.
            cnt_nx = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
            if ((cnt_q == CNT_MAX) && !en_i) begin
              state_d = IDLE;
              sck_d   = 1'b0;
              ws_d    = 1'b0;
              sd_d    = 1'b0;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_nx;
              ws_d  = (cnt_nx >= SLOT_CNT);
              // Sampled from the frame register before it reloads, so the
              // last right bit still comes from the previous frame.
              if (cnt_q < SLOT_CNT) begin
                sd_d = slot_bit(frm_l_q, cnt_q);
              end else begin
                sd_d = slot_bit(frm_r_q, cnt_q - SLOT_CNT);
              end
              frame_load = (cnt_q == CNT_MAX);
            end
          end else begin
            cnt_d = cnt_q;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (frame_load) begin
      if (buf_full_q) begin
        frm_l_d    = buf_l_q;
        frm_r_d    = buf_r_q;
        buf_full_d = 1'b0;
      end else begin
        frm_l_d    = '0;
        frm_r_d    = '0;
        underrun_d = 1'b1;
      end
    end else begin
      underrun_d = 1'b0;
    end

    // An accept can only happen with the buffer empty, so it never collides
    // with a frame consuming the buffer on the same edge.
    if (accept) begin
      buf_full_d = 1'b1;
      buf_l_d    = data_l_i;
      buf_r_d    = data_r_i;
    end else begin
      buf_full_d = buf_full_d;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      div_q      <= '0;
      cnt_q      <= '0;
      sck_q      <= 1'b0;
      ws_q       <= 1'b0;
      sd_q       <= 1'b0;
      underrun_q <= 1'b0;
      buf_full_q <= 1'b0;
      buf_l_q    <= '0;
      buf_r_q    <= '0;
      frm_l_q    <= '0;
      frm_r_q    <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      sck_q      <= sck_d;
      ws_q       <= ws_d;
      sd_q       <= sd_d;
      underrun_q <= underrun_d;
      buf_full_q <= buf_full_d;
      buf_l_q    <= buf_l_d;
      buf_r_q    <= buf_r_d;
      frm_l_q    <= frm_l_d;
      frm_r_q    <= frm_r_d;
    end
  end

  assign ready_o    = ~buf_full_q;
  assign sck_o      = sck_q;
  assign ws_o       = ws_q;
  assign sd_o       = sd_q;
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_i2s_tx_core.sv
module tb_i2s_tx_core;

  logic        clk;
  logic        rst;
  logic        en;
  logic        va, vb;
  logic [23:0] dla, dra;
  logic [31:0] dlb, drb;
  logic        rdy_a, sck_a, ws_a, sd_a, und_a;
  logic        rdy_b, sck_b, ws_b, sd_b, und_b;

  int n_checks;
  int n_fail;

  // Instance A: 24-bit samples, 32-bit slots, SCK = clk/4.
  i2s_tx_core #(.DATA_W(24), .SLOT_W(32), .CLK_DIV(2)) dut_a (
    .clk_i(clk), .rst_i(rst), .en_i(en),
    .data_l_i(dla), .data_r_i(dra), .valid_i(va), .ready_o(rdy_a),
    .sck_o(sck_a), .ws_o(ws_a), .sd_o(sd_a), .underrun_o(und_a)
  );

  // Instance B: sample fills the slot, SCK = clk/2.
  i2s_tx_core #(.DATA_W(32), .SLOT_W(32), .CLK_DIV(1)) dut_b (
    .clk_i(clk), .rst_i(rst), .en_i(en),
    .data_l_i(dlb), .data_r_i(drb), .valid_i(vb), .ready_o(rdy_b),
    .sck_o(sck_b), .ws_o(ws_b), .sd_o(sd_b), .underrun_o(und_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model (one slot per instance) ----------------
  int          cd_v [2] = '{2, 1};
  int          sw_v [2] = '{32, 32};
  int          dw_v [2] = '{24, 32};
  bit          m_run [2];
  int          m_t   [2];   // clk edges since RUN entry
  bit          m_bf  [2];
  logic [31:0] m_bl  [2], m_br [2];
  logic [31:0] m_cl  [2], m_cr [2];
  logic [31:0] m_pr  [2];   // right sample of the previous frame
  bit          m_und [2];

  function automatic logic bit_of(logic [31:0] s, int dw, int k);
    if (k < dw) return s[dw-1-k];
    return 1'b0;
  endfunction

  task automatic model_reset(int i);
    m_run[i] = 0; m_t[i] = 0; m_bf[i] = 0; m_und[i] = 0;
    m_bl[i] = 0; m_br[i] = 0; m_cl[i] = 0; m_cr[i] = 0; m_pr[i] = 0;
  endtask

  task automatic model_load(int i);
    m_pr[i] = m_cr[i];
    if (m_bf[i]) begin
      m_cl[i] = m_bl[i]; m_cr[i] = m_br[i]; m_bf[i] = 0;
    end else begin
      m_cl[i] = 0; m_cr[i] = 0; m_und[i] = 1;
    end
  endtask

  task automatic model_edge(int i, bit e, bit v, logic [31:0] dl, logic [31:0] dr);
    bit old_full;
    int n;
    old_full = m_bf[i];
    m_und[i] = 0;
    if (!m_run[i]) begin
      if (e) begin
        m_run[i] = 1; m_t[i] = 0; m_cr[i] = 0;
        model_load(i);
      end
    end else begin
      m_t[i]++;
      if (m_t[i] % (2 * cd_v[i]) == 0) begin
        n = m_t[i] / (2 * cd_v[i]);
        if (n % (2 * sw_v[i]) == 0) begin
          if (!e) m_run[i] = 0;
          else model_load(i);
        end
      end
    end
    if (v && !old_full) begin
      m_bf[i] = 1; m_bl[i] = dl; m_br[i] = dr;
    end
  endtask

  task automatic check_eq(string tag, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic compare_inst(int i, string nm, logic rdy, logic sck,
                              logic ws, logic sd, logic und);
    logic e_sck, e_ws, e_sd;
    int n, b, p, s;
    s = sw_v[i];
    e_sck = 0; e_ws = 0; e_sd = 0;
    if (m_run[i]) begin
      e_sck = ((m_t[i] / cd_v[i]) % 2) == 1;
      n = m_t[i] / (2 * cd_v[i]);
      b = n % (2 * s);
      e_ws = (b >= s);
      if (b == 0) e_sd = bit_of(m_pr[i], dw_v[i], s - 1);
      else begin
        p = b - 1;
        e_sd = (p < s) ? bit_of(m_cl[i], dw_v[i], p)
                       : bit_of(m_cr[i], dw_v[i], p - s);
      end
    end
    check_eq({nm, ".ready"},    32'(rdy), 32'(!m_bf[i]));
    check_eq({nm, ".sck"},      32'(sck), 32'(e_sck));
    check_eq({nm, ".ws"},       32'(ws),  32'(e_ws));
    check_eq({nm, ".sd"},       32'(sd),  32'(e_sd));
    check_eq({nm, ".underrun"}, 32'(und), 32'(m_und[i]));
  endtask

  // One clock: update the model with the inputs present at the edge, then
  // compare shortly after the edge.
  task automatic cycle();
    @(posedge clk);
    if (rst) begin
      model_reset(0); model_reset(1);
    end else begin
      model_edge(0, en, va, {8'h00, dla}, {8'h00, dra});
      model_edge(1, en, vb, dlb, drb);
    end
    #1;
    compare_inst(0, "A", rdy_a, sck_a, ws_a, sd_a, und_a);
    compare_inst(1, "B", rdy_b, sck_b, ws_b, sd_b, und_b);
  endtask

  task automatic rand_data();
    dla = 24'($urandom); dra = 24'($urandom);
    dlb = $urandom;      drb = $urandom;
  endtask

  task automatic run_cycles(int n, int vprob);
    for (int c = 0; c < n; c++) begin
      va = ($urandom_range(99, 0) < vprob);
      vb = ($urandom_range(99, 0) < vprob);
      rand_data();
      cycle();
    end
  endtask

  int und_cnt;

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; en = 1'b0; va = 1'b0; vb = 1'b0;
    dla = 24'h0; dra = 24'h0; dlb = 32'h0; drb = 32'h0;
    model_reset(0); model_reset(1);

    // Reset state
    repeat (3) cycle();
    rst = 1'b0;
    cycle();

    // Directed frame: A gets A5A5A5/3C3C3C, B gets right = 1 (full-slot LSB)
    va = 1'b1; dla = 24'hA5A5A5; dra = 24'h3C3C3C;
    vb = 1'b1; dlb = 32'h8000_0001; drb = 32'h0000_0001;
    cycle();
    va = 1'b0; vb = 1'b0; en = 1'b1;
    cycle();
    check_eq("A.first_sd", 32'(sd_a), 32'd0);
    repeat (520) cycle();

    // No pairs written: A underruns once per 256 clocks
    und_cnt = 0;
    for (int c = 0; c < 768; c++) begin
      cycle();
      if (und_a) und_cnt++;
    end
    check_eq("A.underrun_count", 32'(und_cnt), 32'd3);

    // Random sparse stream
    run_cycles(1500, 25);
    // Back-to-back stream with valid held high
    run_cycles(1100, 100);

    // Stop mid-frame, buffer full while idle, then restart
    for (int c = 0; c < 40; c++) begin va = 1; vb = 1; rand_data(); cycle(); end
    en = 1'b0;
    run_cycles(700, 100);
    check_eq("A.idle_ready", 32'(rdy_a), 32'd0);
    check_eq("A.idle_sck", 32'(sck_a), 32'd0);
    en = 1'b1;
    run_cycles(600, 30);

    // Brief enable drop inside a frame has no effect
    en = 1'b0;
    run_cycles(20, 30);
    en = 1'b1;
    run_cycles(600, 30);

    // Asynchronous reset between clock edges
    #2;
    rst = 1'b1;
    #1;
    check_eq("A.async_sck", 32'(sck_a), 32'd0);
    check_eq("A.async_ws",  32'(ws_a),  32'd0);
    check_eq("A.async_sd",  32'(sd_a),  32'd0);
    check_eq("A.async_rdy", 32'(rdy_a), 32'd1);
    check_eq("B.async_rdy", 32'(rdy_b), 32'd1);
    check_eq("B.async_und", 32'(und_b), 32'd0);
    run_cycles(3, 50);
    rst = 1'b0;

    // Random enable toggling
    for (int blk = 0; blk < 12; blk++) begin
      en = ($urandom_range(3, 0) != 0);
      run_cycles($urandom_range(250, 20), 40);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_tx_core.md
I2S_TX_CORE -- requirements
Module: i2s_tx_core

Interface
REQ-001 Parameter DATA_W, default 24, sample width in bits per channel; legal range 1..SLOT_W.
REQ-002 Parameter SLOT_W, default 32, SCK periods per channel slot; a frame is 2*SLOT_W SCK periods.
REQ-003 Parameter CLK_DIV, default 4, clk_i cycles per SCK half-period; legal range >= 1.
REQ-004 clk_i  in  1  single system clock; all flops on its rising edge.
REQ-005 rst_i  in  1  reset; asynchronous, active-high.
REQ-006 en_i  in  1  transmit enable.
REQ-007 data_l_i  in  DATA_W  left-channel sample, two's complement.
REQ-008 data_r_i  in  DATA_W  right-channel sample, two's complement.
REQ-009 valid_i  in  1  sample pair valid.
REQ-010 ready_o  out  1  input buffer can accept a pair.
REQ-011 sck_o  out  1  I2S serial clock, master mode.
REQ-012 ws_o  out  1  word select; 0 = left, 1 = right.
REQ-013 sd_o  out  1  serial data, MSB first.
REQ-014 underrun_o  out  1  one clk_i pulse when a frame starts with no buffered pair.

Function
REQ-015 One-entry input buffer: ready_o = buffer empty; a pair is accepted on any clk_i edge with valid_i & ready_o, independent of en_i.
REQ-016 States IDLE and RUN; IDLE holds sck_o = ws_o = sd_o = 0, divider and bit counter cleared.
REQ-017 IDLE -> RUN on the first cycle with en_i = 1; on that edge bit_cnt = 0 and the frame register loads from the buffer (zeros plus underrun_o pulse if buffer empty).
REQ-018 In RUN, the divider counts 0..CLK_DIV-1; on wrap sck_o toggles, so SCK period = 2*CLK_DIV clk_i cycles, first toggle (rising) CLK_DIV cycles after RUN entry.
REQ-019 All ws_o/sd_o updates occur only on the clk_i edge that drives sck_o 1 -> 0 (falling event); bit_cnt then advances modulo 2*SLOT_W.
REQ-020 With new bit_cnt value b: ws_o = (b >= SLOT_W); sd_o carries slot position p = (b-1) mod 2*SLOT_W (one-SCK I2S delay).
REQ-021 For position p: channel = left if p < SLOT_W else right; k = p mod SLOT_W; bit = sample[DATA_W-1-k] if k < DATA_W, else 0.
REQ-022 Position p = 2*SLOT_W-1 (output while b = 0) uses the previous frame's right sample; on RUN entry it is 0.
REQ-023 Frame start = falling event where bit_cnt wraps to 0: buffer full -> pair moves to frame register, buffer empties, ready_o = 1 next cycle; buffer empty -> frame register loads zeros, underrun_o = 1 for that one cycle.
REQ-024 Accept and frame start on the same edge with buffer empty: frame takes zeros with underrun_o pulse; accepted pair stays buffered for the next frame.
REQ-025 en_i = 0 during RUN: current frame completes; at the falling event that would wrap bit_cnt to 0 the block enters IDLE without consuming the buffer or pulsing underrun_o.
REQ-026 en_i re-asserted before that frame end: no effect; transmission continues seamlessly.

Reset
REQ-027 While rst_i = 1, and immediately after, state = IDLE, sck_o = ws_o = sd_o = 0, underrun_o = 0, buffer empty, ready_o = 1, counters and frame register zero.
REQ-028 rst_i asserted mid-frame aborts at once to these values; any buffered pair is discarded.

Verification
REQ-029 DATA_W=24, SLOT_W=32, CLK_DIV=2; load L=0xA5A5A5, R=0x3C3C3C, raise en_i -> sck_o period 4 clk_i; first falling event: ws_o=0, sd_o=1 (L MSB); left bits 1,0,1,0,0,1,0,1,... then 8 zeros; ws_o=1 one SCK before R MSB 0.
REQ-030 Same setup, no pair written -> underrun_o pulses exactly once per frame (every 256 clk_i cycles), sd_o constant 0, ws_o still toggles every 32 SCK.
REQ-031 Stream pairs back-to-back with valid_i held 1 -> ready_o low from accept until next frame start, high one cycle after; no pair dropped or duplicated across 4 frames.
REQ-032 Drop en_i at SCK 10 of a frame -> frame completes all 64 SCK, then sck_o/ws_o/sd_o = 0; buffered pair still present (ready_o = 0) and sent first after en_i returns.
REQ-033 DATA_W=SLOT_W=32, R=0x00000001 -> right LSB 1 appears on sd_o while b = 0 of the next frame, ws_o = 0.
REQ-034 Assert rst_i asynchronously mid-slot, between clk_i edges -> all outputs at reset values before the next clk_i edge; ready_o = 1.
